// File: rtl/alu_ctrl_dmem.sv
// Single-cycle RV32I ALU, decode/control FSM and 256x32 data memory with a two-cycle load.
// Define ALU_SHIFT_EN to build in SLL/SRL/SRA; without it, shift instructions retire as NOPs.
module alu_ctrl_dmem (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic [3:0]  alu_op_code,
    output logic        reg_or_imm_mux,
    output logic        data_read,
    output logic        data_write,
    output logic        alu_data_mux,
    output logic        pc_mux,
    output logic        reg_write,
    output logic        pc_en,
    output logic [31:0] alu_out,
    output logic        branch,
    output logic [31:0] wb_data
);
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_IALU   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SLL  = 4'h5;
    localparam logic [3:0] OP_SRL  = 4'h6;
    localparam logic [3:0] OP_SRA  = 4'h7;
    localparam logic [3:0] OP_SLT  = 4'h8;
    localparam logic [3:0] OP_SLTU = 4'h9;
    localparam logic [3:0] OP_BEQ  = 4'hA;
    localparam logic [3:0] OP_BNE  = 4'hB;
    localparam logic [3:0] OP_BLT  = 4'hC;
    localparam logic [3:0] OP_BGE  = 4'hD;
    localparam logic [3:0] OP_BLTU = 4'hE;
    localparam logic [3:0] OP_BGEU = 4'hF;

    typedef enum logic [0:0] {EXEC, MEM_WAIT} state_t;

    state_t      state_reg;
    logic [31:0] q_reg;
    logic [31:0] mem [0:255];

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic        is_rtype, is_ialu, is_load, is_store, is_branch;
    logic        shift_nop;
    logic [31:0] imm;
    logic [31:0] operand2;
    logic [7:0]  mem_index;
    logic        unused_rs1_field;

    assign opcode    = instruction[6:0];
    assign funct3    = instruction[14:12];
    assign funct7_5  = instruction[30];
    assign is_rtype  = (opcode == OPC_RTYPE);
    assign is_ialu   = (opcode == OPC_IALU);
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_branch = (opcode == OPC_BRANCH);
    // rs1 index is resolved by the register file outside this block
    assign unused_rs1_field = ^instruction[19:15];

`ifdef ALU_SHIFT_EN
    assign shift_nop = 1'b0;
`else
    assign shift_nop = (is_rtype || is_ialu) && (funct3 == 3'b001 || funct3 == 3'b101);
`endif

    assign imm = is_store ? {{20{instruction[31]}}, instruction[31:25], instruction[11:7]}
                          : {{20{instruction[31]}}, instruction[31:20]};
    assign reg_or_imm_mux = is_ialu || is_load || is_store;
    assign operand2       = reg_or_imm_mux ? imm : rs2_data;

    always_comb begin
        alu_op_code = OP_ADD;
        if (is_rtype || is_ialu) begin
            case (funct3)
                3'b000:  alu_op_code = (is_rtype && funct7_5) ? OP_SUB : OP_ADD;
                3'b001:  alu_op_code = OP_SLL;
                3'b010:  alu_op_code = OP_SLT;
                3'b011:  alu_op_code = OP_SLTU;
                3'b100:  alu_op_code = OP_XOR;
                3'b101:  alu_op_code = funct7_5 ? OP_SRA : OP_SRL;
                3'b110:  alu_op_code = OP_OR;
                default: alu_op_code = OP_AND;
            endcase
        end else if (is_branch) begin
            case (funct3)
                3'b001:  alu_op_code = OP_BNE;
                3'b100:  alu_op_code = OP_BLT;
                3'b101:  alu_op_code = OP_BGE;
                3'b110:  alu_op_code = OP_BLTU;
                3'b111:  alu_op_code = OP_BGEU;
                default: alu_op_code = OP_BEQ;
            endcase
        end
    end

    // Branch ops only drive the condition flag; their numeric result is 0.
    always_comb begin
        alu_out = 32'd0;
        branch  = 1'b0;
        case (alu_op_code)
            OP_ADD:  alu_out = rs1_data + operand2;
            OP_SUB:  alu_out = rs1_data - operand2;
            OP_AND:  alu_out = rs1_data & operand2;
            OP_OR:   alu_out = rs1_data | operand2;
            OP_XOR:  alu_out = rs1_data ^ operand2;
`ifdef ALU_SHIFT_EN
            OP_SLL:  alu_out = rs1_data << operand2[4:0];
            OP_SRL:  alu_out = rs1_data >> operand2[4:0];
            OP_SRA:  alu_out = $unsigned($signed(rs1_data) >>> operand2[4:0]);
`endif
            OP_SLT:  alu_out = {31'd0, $signed(rs1_data) < $signed(operand2)};
            OP_SLTU: alu_out = {31'd0, rs1_data < operand2};
            OP_BEQ:  branch  = (rs1_data == operand2);
            OP_BNE:  branch  = (rs1_data != operand2);
            OP_BLT:  branch  = ($signed(rs1_data) < $signed(operand2));
            OP_BGE:  branch  = ($signed(rs1_data) >= $signed(operand2));
            OP_BLTU: branch  = (rs1_data < operand2);
            OP_BGEU: branch  = (rs1_data >= operand2);
            default: alu_out = 32'd0;
        endcase
    end

    always_comb begin
        data_read    = 1'b0;
        data_write   = 1'b0;
        alu_data_mux = 1'b0;
        pc_mux       = 1'b0;
        reg_write    = 1'b0;
        pc_en        = 1'b0;
        if (rst) begin
            if (state_reg == MEM_WAIT) begin
                alu_data_mux = 1'b1;
                reg_write    = 1'b1;
                pc_en        = 1'b1;
            end else begin
                pc_en      = !is_load;
                data_read  = is_load;
                data_write = is_store;
                pc_mux     = is_branch;
                reg_write  = (is_rtype || is_ialu) && !shift_nop;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= EXEC;
        end else begin
            case (state_reg)
                EXEC:     state_reg <= data_read ? MEM_WAIT : EXEC;
                default:  state_reg <= EXEC;
            endcase
        end
    end

    assign mem_index = alu_out[9:2];

    // No reset on the array so contents survive rst and map to block RAM.
    always_ff @(posedge clk) begin
        if (data_write && rst)
            mem[mem_index] <= rs2_data;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            q_reg <= 32'd0;
        else if (data_read)
            q_reg <= mem[mem_index];
    end

    assign wb_data = alu_data_mux ? q_reg : alu_out;

endmodule

// File: tb/tb_alu_ctrl_dmem.sv
// Directed bench for alu_ctrl_dmem: a behavioural model checked every cycle plus literal pins.
// Follows ALU_SHIFT_EN the same way as the design build.
module tb_alu_ctrl_dmem;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instruction = 32'd0;
    logic [31:0] rs1_data = 32'd0;
    logic [31:0] rs2_data = 32'd0;
    logic [3:0]  alu_op_code;
    logic        reg_or_imm_mux, data_read, data_write, alu_data_mux;
    logic        pc_mux, reg_write, pc_en, branch;
    logic [31:0] alu_out, wb_data;

    always #5 clk = ~clk;

    alu_ctrl_dmem dut (
        .clk(clk), .rst(rst), .instruction(instruction),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .alu_op_code(alu_op_code), .reg_or_imm_mux(reg_or_imm_mux),
        .data_read(data_read), .data_write(data_write),
        .alu_data_mux(alu_data_mux), .pc_mux(pc_mux), .reg_write(reg_write),
        .pc_en(pc_en), .alu_out(alu_out), .branch(branch), .wb_data(wb_data)
    );

    int errors = 0;
    int checks = 0;

    logic [3:0]  e_op;
    logic        e_rim, e_rd, e_wr, e_adm, e_pcm, e_rw, e_pce, e_br;
    logic [31:0] e_alu, e_wb;
    bit          e_nop;
    bit          chk_en = 0;
    int          lit_kind = 0;
    logic [31:0] lit_val = 32'd0;

    bit          m_wait = 0;
    logic [31:0] m_q = 32'd0;
    logic [31:0] m_mem [int];

    function automatic logic [31:0] rt(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction
    function automatic logic [31:0] it(input logic [11:0] imm, input logic [2:0] f3, input logic [6:0] opc);
        return {imm, 5'd1, f3, 5'd3, opc};
    endfunction
    function automatic logic [31:0] st(input logic [11:0] imm);
        return {imm[11:5], 5'd2, 5'd1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] bt(input logic [2:0] f3);
        return {7'd0, 5'd2, 5'd1, f3, 5'd0, 7'b1100011};
    endfunction

    // Expected outputs for the present inputs, straight from the instruction semantics.
    task automatic model_eval();
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] a, b, imm_i, imm_s;
        opc   = instruction[6:0];
        f3    = instruction[14:12];
        f7    = instruction[30];
        a     = rs1_data;
        imm_i = {{20{instruction[31]}}, instruction[31:20]};
        imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
        {e_rim, e_rd, e_wr, e_adm, e_pcm, e_rw, e_pce, e_br} = '0;
        e_op = 4'h0; e_alu = 32'd0; e_nop = 0;
        case (opc)
            7'b0110011, 7'b0010011: begin
                b     = (opc == 7'b0110011) ? rs2_data : imm_i;
                e_rim = (opc == 7'b0010011);
                e_rw  = 1; e_pce = 1;
                case (f3)
                    3'd0: if (opc == 7'b0110011 && f7) begin e_op = 4'h1; e_alu = a - b; end
                          else begin e_op = 4'h0; e_alu = a + b; end
                    3'd1: begin e_op = 4'h5; e_alu = a << (b % 32); end
                    3'd2: begin e_op = 4'h8; e_alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
                    3'd3: begin e_op = 4'h9; e_alu = (a < b) ? 32'd1 : 32'd0; end
                    3'd4: begin e_op = 4'h4; e_alu = a ^ b; end
                    3'd5: if (f7) begin e_op = 4'h7; e_alu = $unsigned($signed(a) >>> (b % 32)); end
                          else begin e_op = 4'h6; e_alu = a >> (b % 32); end
                    3'd6: begin e_op = 4'h3; e_alu = a | b; end
                    default: begin e_op = 4'h2; e_alu = a & b; end
                endcase
`ifndef ALU_SHIFT_EN
                if (f3 == 3'd1 || f3 == 3'd5) begin e_alu = 32'd0; e_rw = 0; end
`endif
            end
            7'b0000011: begin
                e_rim = 1; e_alu = a + imm_i;
                if (m_wait) begin e_adm = 1; e_rw = 1; e_pce = 1; end
                else e_rd = 1;
            end
            7'b0100011: begin e_rim = 1; e_wr = 1; e_pce = 1; e_alu = a + imm_s; end
            7'b1100011: begin
                e_pcm = 1; e_pce = 1;
                case (f3)
                    3'd1: begin e_op = 4'hB; e_br = (a != rs2_data); end
                    3'd4: begin e_op = 4'hC; e_br = ($signed(a) < $signed(rs2_data)); end
                    3'd5: begin e_op = 4'hD; e_br = ($signed(a) >= $signed(rs2_data)); end
                    3'd6: begin e_op = 4'hE; e_br = (a < rs2_data); end
                    3'd7: begin e_op = 4'hF; e_br = (a >= rs2_data); end
                    default: begin e_op = 4'hA; e_br = (a == rs2_data); end
                endcase
            end
            default: begin e_nop = 1; e_pce = 1; end
        endcase
        if (!rst) {e_rd, e_wr, e_adm, e_pcm, e_rw, e_pce} = '0;
        e_wb = e_adm ? m_q : e_alu;
    endtask

    task automatic model_commit();
        int idx;
        idx = int'((e_alu & 32'h3FF) >> 2);
        if (!rst) begin
            m_wait = 0; m_q = 32'd0;
        end else if (m_wait) begin
            m_wait = 0;
        end else if (instruction[6:0] == 7'b0000011) begin
            m_q = m_mem.exists(idx) ? m_mem[idx] : 32'd0;
            m_wait = 1;
        end else if (instruction[6:0] == 7'b0100011) begin
            m_mem[idx] = rs2_data;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (instr 0x%08h rst %0b)",
                     name, act, exp, instruction, rst);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("reg_or_imm_mux", {31'd0, reg_or_imm_mux}, {31'd0, e_nop ? 1'b0 : e_rim});
            chk("data_read",      {31'd0, data_read},      {31'd0, e_rd});
            chk("data_write",     {31'd0, data_write},     {31'd0, e_wr});
            chk("alu_data_mux",   {31'd0, alu_data_mux},   {31'd0, e_adm});
            chk("pc_mux",         {31'd0, pc_mux},         {31'd0, e_pcm});
            chk("reg_write",      {31'd0, reg_write},      {31'd0, e_rw});
            chk("pc_en",          {31'd0, pc_en},          {31'd0, e_pce});
            chk("branch",         {31'd0, branch},         {31'd0, e_br});
            if (!e_nop) begin
                chk("alu_op_code", {28'd0, alu_op_code}, {28'd0, e_op});
                chk("alu_out",     alu_out, e_alu);
                chk("wb_data",     wb_data, e_wb);
            end
            case (lit_kind)
                1: chk("lit_alu_out",   alu_out, lit_val);
                2: chk("lit_wb_data",   wb_data, lit_val);
                3: chk("lit_branch",    {31'd0, branch}, lit_val);
                4: chk("lit_reg_write", {31'd0, reg_write}, lit_val);
                5: chk("lit_pc_en",     {31'd0, pc_en}, lit_val);
                default: ;
            endcase
            $display("cycle instr=0x%08h rs1=0x%08h rs2=0x%08h rst=%0b alu_out=0x%08h wb=0x%08h rw=%0b pce=%0b",
                     instruction, rs1_data, rs2_data, rst, alu_out, wb_data, reg_write, pc_en);
        end
    end

    task automatic step(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                        input logic r, input int lk, input logic [31:0] lv);
        instruction = ins; rs1_data = a; rs2_data = b; rst = r;
        lit_kind = lk; lit_val = lv;
        model_eval();
        chk_en = 1;
        @(posedge clk);
        model_commit();
        #1;
    endtask

    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] OPL = 7'b0000011;

    logic [31:0] x_sra, x_sll, x_srl;

    initial begin
`ifdef ALU_SHIFT_EN
        x_sra = 32'hF8000000; x_sll = 32'h00000002; x_srl = 32'h08000000;
`else
        x_sra = 32'h0; x_sll = 32'h0; x_srl = 32'h0;
`endif
        @(posedge clk); #1;
        step(it(12'd1, 3'd0, OPI), 32'h0, 32'h0, 1'b0, 4, 32'd0);
        step(st(12'd0), 32'h0, 32'h0, 1'b0, 0, 32'd0);
        // arithmetic and logic
        step(it(12'd1, 3'd0, OPI), 32'h7FFFFFFF, 32'h0, 1'b1, 1, 32'h80000000);
        step(rt(7'h00, 3'd0), 32'd5, 32'd7, 1'b1, 1, 32'd12);
        step(rt(7'h20, 3'd0), 32'd5, 32'd7, 1'b1, 1, 32'hFFFFFFFE);
        step(it(12'hFFF, 3'd0, OPI), 32'd10, 32'd0, 1'b1, 1, 32'd9);
        step(rt(7'h00, 3'd7), 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 1, 32'hF000F000);
        step(rt(7'h00, 3'd6), 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 1, 32'hFFF0FFF0);
        step(rt(7'h00, 3'd4), 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 1, 32'h0FF00FF0);
        step(rt(7'h00, 3'd2), 32'hFFFFFFFF, 32'd1, 1'b1, 1, 32'd1);
        step(rt(7'h00, 3'd3), 32'hFFFFFFFF, 32'd1, 1'b1, 1, 32'd0);
        step(it(12'hFFF, 3'd2, OPI), 32'd0, 32'd0, 1'b1, 1, 32'd0);
        step(it(12'hFFF, 3'd3, OPI), 32'd0, 32'd0, 1'b1, 1, 32'd1);
        // shifts
        step(rt(7'h20, 3'd5), 32'h80000000, 32'd4, 1'b1, 1, x_sra);
        step(rt(7'h00, 3'd1), 32'd1, 32'h21, 1'b1, 1, x_sll);
        step(it(12'h004, 3'd5, OPI), 32'h80000000, 32'd0, 1'b1, 1, x_srl);
        step(it(12'h404, 3'd5, OPI), 32'h80000000, 32'd0, 1'b1, 1, x_sra);
        // store / load, including negative offset and 1 KiB wrap
        step(st(12'd4), 32'h10, 32'hDEADBEEF, 1'b1, 1, 32'h14);
        step(it(12'd4, 3'd2, OPL), 32'h10, 32'd0, 1'b1, 5, 32'd0);
        step(it(12'd4, 3'd2, OPL), 32'h10, 32'd0, 1'b1, 2, 32'hDEADBEEF);
        step(st(12'hFFC), 32'h20, 32'h12345678, 1'b1, 1, 32'h1C);
        step(it(12'd0, 3'd2, OPL), 32'h1C, 32'd0, 1'b1, 0, 32'd0);
        step(it(12'd0, 3'd2, OPL), 32'h1C, 32'd0, 1'b1, 2, 32'h12345678);
        step(st(12'd0), 32'h400, 32'hCAFEF00D, 1'b1, 0, 32'd0);
        step(it(12'd0, 3'd2, OPL), 32'h0, 32'd0, 1'b1, 0, 32'd0);
        step(it(12'd0, 3'd2, OPL), 32'h0, 32'd0, 1'b1, 2, 32'hCAFEF00D);
        // branches
        step(bt(3'd4), 32'hFFFFFFFF, 32'd1, 1'b1, 3, 32'd1);
        step(bt(3'd6), 32'hFFFFFFFF, 32'd1, 1'b1, 3, 32'd0);
        step(bt(3'd0), 32'd5, 32'd5, 1'b1, 3, 32'd1);
        step(bt(3'd1), 32'd5, 32'd5, 1'b1, 3, 32'd0);
        step(bt(3'd5), 32'd1, 32'hFFFFFFFF, 1'b1, 3, 32'd1);
        step(bt(3'd7), 32'd1, 32'hFFFFFFFF, 1'b1, 3, 32'd0);
        // reset during MEM_WAIT aborts the load; a store under reset is dropped
        step(it(12'd4, 3'd2, OPL), 32'h10, 32'd0, 1'b1, 5, 32'd0);
        step(it(12'd4, 3'd2, OPL), 32'h10, 32'd0, 1'b0, 4, 32'd0);
        step(st(12'd4), 32'h10, 32'h0BAD0BAD, 1'b0, 0, 32'd0);
        step(32'h0000006F, 32'd3, 32'd4, 1'b1, 5, 32'd1);
        step(it(12'd4, 3'd2, OPL), 32'h10, 32'd0, 1'b1, 5, 32'd0);
        step(it(12'd4, 3'd2, OPL), 32'h10, 32'd0, 1'b1, 2, 32'hDEADBEEF);
        step(32'h00000000, 32'd1, 32'd1, 1'b1, 4, 32'd0);
        chk_en = 0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
